scope_buffer: RTL and testbench

- Parametrised successor to the TMB 2-channel miniscope RAM: NCH channels x WIDTH bits, continuous circular recording, DEPTH = 2**ADRB tbins.
- On trigger, a readout sequencer replays `tbins` samples starting `pretrig` samples before the trigger, after waiting for the post-trigger samples to be written.
- Per-channel parity is stored and checked on read, with sticky error flags.
- Test mode writes data = address.
- Sits between the trigger/sequencer logic and the DMB readout stream.

---
 rtl/scope_buffer.sv | 153 +++++++++++++++
 tb/tb_scope_buffer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/scope_buffer.sv
`default_nettype none
// ============================================================================
// scope_buffer : NCH-channel circular scope RAM with trigger-driven readout
// Rev 1.0
// ============================================================================
module scope_buffer #(
   parameter int NCH   = 2,
   parameter int WIDTH = 8,
   parameter int ADRB  = 11
) (
   input  logic                 clock,
   input  logic                 reset_n,
   input  logic                 wr_en,
   input  logic [NCH*WIDTH-1:0] wr_data,
   input  logic                 test_mode,
   input  logic                 trig,
   input  logic [7:0]           pretrig,
   input  logic [7:0]           tbins,
   output logic                 rd_busy,
   output logic                 rd_valid,
   output logic [NCH*WIDTH-1:0] rd_data,
   output logic [7:0]           rd_tbin,
   output logic                 rd_done,
   output logic                 trig_lost,
   output logic [NCH-1:0]       parity_err,
   input  logic                 parity_err_clr
);
   localparam int DW    = NCH*WIDTH;
   localparam int RW    = DW + NCH;
   localparam int DEPTH = 2**ADRB;

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] WAIT  = 3'd1;
   localparam logic [2:0] READ  = 3'd2;
   localparam logic [2:0] DRAIN = 3'd3;
   localparam logic [2:0] DONE  = 3'd4;

   logic [1:0]      rst_sync;
   logic            rst_n;
   logic            test_ff;
   logic [ADRB-1:0] wadr;
   logic [DW-1:0]   adr_data;
   logic [DW-1:0]   wdata;
   logic [NCH-1:0]  wpar;
   logic [RW-1:0]   mem [DEPTH];
   logic [2:0]      state;
   logic [ADRB-1:0] radr;
   logic [ADRB-1:0] pre_ext;
   logic [7:0]      post;
   logic [7:0]      cnt;
   logic            rd_en;
   logic [RW-1:0]   rd_word;
   logic [NCH-1:0]  par_bad;

   // Reset asserts immediately but releases on a clock edge
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) rst_sync <= 2'b00;
      else          rst_sync <= {rst_sync[0], 1'b1};
   end
   assign rst_n = rst_sync[1];

   generate
      if (DW > ADRB) begin : g_adr_pad
         assign adr_data = {{(DW-ADRB){1'b0}}, wadr};
      end else begin : g_adr_trunc
         assign adr_data = wadr[DW-1:0];
      end
   endgenerate

   assign wdata = test_ff ? adr_data : wr_data;

   generate
      for (genvar c = 0; c < NCH; c++) begin : g_par
         assign wpar[c]    = ~^wdata[c*WIDTH +: WIDTH];
         assign par_bad[c] = rd_valid &
                             ((~^rd_word[c*WIDTH +: WIDTH]) != rd_word[DW+c]);
      end
   endgenerate

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         test_ff <= 1'b0;
         wadr    <= '0;
      end else begin
         test_ff <= test_mode;
         if (wr_en) wadr <= wadr + 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (wr_en && rst_n) mem[wadr] <= {wpar, wdata};
   end

   assign pre_ext = {{(ADRB-8){1'b0}}, pretrig};
   assign rd_en   = (state == READ);

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         radr  <= '0;
         post  <= '0;
         cnt   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (trig) begin
                  radr  <= wadr - pre_ext;
                  post  <= (tbins > pretrig) ? (tbins - pretrig - 8'd1) : 8'd0;
                  cnt   <= tbins;
                  state <= (tbins == 8'd0) ? DONE : WAIT;
               end
            end
            WAIT: begin
               // Hold off until the newest sample of the window is in RAM
               if (post == 8'd0) state <= READ;
               else if (wr_en)   post  <= post - 8'd1;
            end
            READ: begin
               radr <= radr + 1'b1;
               cnt  <= cnt - 8'd1;
               if (cnt == 8'd1) state <= DRAIN;
            end
            DRAIN:   state <= DONE;
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (rd_en) rd_word <= mem[radr];
   end

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         rd_valid   <= 1'b0;
         rd_tbin    <= '0;
         trig_lost  <= 1'b0;
         parity_err <= '0;
      end else begin
         rd_valid   <= rd_en;
         rd_tbin    <= rd_en ? (rd_valid ? rd_tbin + 8'd1 : 8'd0) : 8'd0;
         trig_lost  <= trig && (state != IDLE);
         parity_err <= (parity_err & ~{NCH{parity_err_clr}}) | par_bad;
      end
   end

   assign rd_data = rd_valid ? rd_word[DW-1:0] : '0;
   assign rd_busy = (state != IDLE);
   assign rd_done = (state == DONE);

endmodule
`default_nettype wire

// File: tb/tb_scope_buffer.sv
`default_nettype none
// ============================================================================
// tb_scope_buffer : directed self-checking bench for scope_buffer
// Rev 1.0
// ============================================================================
module tb_scope_buffer;
   localparam int NCH   = 2;
   localparam int WIDTH = 8;
   localparam int ADRB  = 11;

   logic        clock = 1'b0;
   logic        reset_n = 1'b1;
   logic        wr_en = 1'b0;
   logic [15:0] wr_data = '0;
   logic        test_mode = 1'b0;
   logic        trig = 1'b0;
   logic [7:0]  pretrig = '0;
   logic [7:0]  tbins = '0;
   logic        parity_err_clr = 1'b0;
   logic        rd_busy, rd_valid, rd_done, trig_lost;
   logic [15:0] rd_data;
   logic [7:0]  rd_tbin;
   logic [1:0]  parity_err;

   int n_chk  = 0;
   int n_fail = 0;
   int wadr_m = 0;

   always #5 clock = ~clock;

   scope_buffer #(.NCH(NCH), .WIDTH(WIDTH), .ADRB(ADRB)) dut (
      .clock(clock), .reset_n(reset_n), .wr_en(wr_en), .wr_data(wr_data),
      .test_mode(test_mode), .trig(trig), .pretrig(pretrig), .tbins(tbins),
      .rd_busy(rd_busy), .rd_valid(rd_valid), .rd_data(rd_data),
      .rd_tbin(rd_tbin), .rd_done(rd_done), .trig_lost(trig_lost),
      .parity_err(parity_err), .parity_err_clr(parity_err_clr)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      if (wr_en && reset_n) wadr_m = (wadr_m + 1) % 2048;
      #1;
   endtask

   task automatic run_to(input int a);
      int g = 0;
      wr_en = 1'b1;
      while (wadr_m != a && g < 5000) begin tick(); g++; end
   endtask

   task automatic do_trig(input int pt, input int tb);
      pretrig = 8'(pt);
      tbins   = 8'(tb);
      trig    = 1'b1;
      tick();
      trig    = 1'b0;
   endtask

   task automatic expect_readout(input string tag, input int start, input int n);
      int w = 0;
      while (!rd_valid && w < 60) begin tick(); w++; end
      chk({tag, "_first_valid"}, 32'(rd_valid), 32'd1);
      for (int i = 0; i < n; i++) begin
         chk({tag, "_data"}, 32'(rd_data), 32'((start + i) % 2048));
         chk({tag, "_tbin"}, 32'(rd_tbin), 32'(i));
         chk({tag, "_valid"}, 32'(rd_valid), 32'd1);
         chk({tag, "_early_done"}, 32'(rd_done), 32'd0);
         tick();
      end
      chk({tag, "_valid_end"}, 32'(rd_valid), 32'd0);
      chk({tag, "_done"}, 32'(rd_done), 32'd1);
      tick();
      chk({tag, "_done_pulse"}, 32'(rd_done), 32'd0);
      chk({tag, "_idle"}, 32'(rd_busy), 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int writes;
      int w;
      int seen;

      // Reset state
      #2 reset_n = 1'b0;
      test_mode = 1'b1;
      repeat (3) tick();
      chk("rst_busy", 32'(rd_busy), 32'd0);
      chk("rst_valid", 32'(rd_valid), 32'd0);
      chk("rst_data", 32'(rd_data), 32'd0);
      chk("rst_tbin", 32'(rd_tbin), 32'd0);
      chk("rst_done", 32'(rd_done), 32'd0);
      chk("rst_lost", 32'(trig_lost), 32'd0);
      chk("rst_perr", 32'(parity_err), 32'd0);
      reset_n = 1'b1;
      repeat (4) tick();
      wadr_m = 0;

      // Normal readout around wadr 100
      run_to(100);
      do_trig(4, 8);
      expect_readout("t1", 96, 8);
      chk("t1_perr", 32'(parity_err), 32'd0);

      // Second trigger while waiting is dropped
      run_to(300);
      do_trig(0, 6);
      tick();
      trig = 1'b1;
      tick();
      trig = 1'b0;
      chk("t4_lost", 32'(trig_lost), 32'd1);
      tick();
      chk("t4_lost_pulse", 32'(trig_lost), 32'd0);
      expect_readout("t4", 300, 6);
      seen = 0;
      repeat (20) begin tick(); if (rd_valid || rd_busy) seen++; end
      chk("t4_no_second", 32'(seen), 32'd0);

      // Post-trigger wait with sparse writes
      run_to(400);
      do_trig(0, 10);
      wr_en = 1'b0;
      writes = 0;
      w = 0;
      while (!rd_valid && w < 100) begin
         if (wr_en) writes++;
         tick();
         wr_en = ~wr_en;
         w++;
      end
      chk("t3_writes", 32'(writes), 32'd10);
      wr_en = 1'b1;
      expect_readout("t3", 400, 10);

      // Parity error on channel 1 at a single address
      run_to(510);
      dut.mem[505][17] = ~dut.mem[505][17];
      chk("t5_perr_pre", 32'(parity_err), 32'd0);
      do_trig(8, 8);
      expect_readout("t5", 502, 8);
      chk("t5_perr", 32'(parity_err), 32'd2);
      repeat (3) tick();
      chk("t5_perr_hold", 32'(parity_err), 32'd2);
      parity_err_clr = 1'b1;
      tick();
      parity_err_clr = 1'b0;
      chk("t5_perr_clr", 32'(parity_err), 32'd0);

      // Clear held high while errors keep arriving
      run_to(600);
      for (int a = 592; a < 600; a++) dut.mem[a][17] = ~dut.mem[a][17];
      do_trig(8, 8);
      w = 0;
      while (!rd_valid && w < 60) begin tick(); w++; end
      parity_err_clr = 1'b1;
      for (int i = 0; i < 8; i++) begin
         chk("t5b_data", 32'(rd_data), 32'(592 + i));
         tick();
      end
      parity_err_clr = 1'b0;
      chk("t5b_set_wins", 32'(parity_err), 32'd2);
      chk("t5b_done", 32'(rd_done), 32'd1);
      tick();
      parity_err_clr = 1'b1;
      tick();
      parity_err_clr = 1'b0;

      // Zero-length readout
      do_trig(0, 0);
      chk("t6a_busy", 32'(rd_busy), 32'd1);
      chk("t6a_done", 32'(rd_done), 32'd1);
      chk("t6a_valid", 32'(rd_valid), 32'd0);
      tick();
      chk("t6a_busy_end", 32'(rd_busy), 32'd0);
      chk("t6a_done_end", 32'(rd_done), 32'd0);
      chk("t6a_valid_end", 32'(rd_valid), 32'd0);

      // Reset in the middle of a readout
      run_to(700);
      do_trig(2, 20);
      w = 0;
      while (!rd_valid && w < 60) begin tick(); w++; end
      repeat (5) tick();
      chk("t6b_mid_valid", 32'(rd_valid), 32'd1);
      reset_n = 1'b0;
      wr_en   = 1'b0;
      #1;
      chk("t6b_busy", 32'(rd_busy), 32'd0);
      chk("t6b_valid", 32'(rd_valid), 32'd0);
      chk("t6b_data", 32'(rd_data), 32'd0);
      chk("t6b_tbin", 32'(rd_tbin), 32'd0);
      chk("t6b_done", 32'(rd_done), 32'd0);
      seen = 0;
      repeat (3) begin tick(); if (rd_valid || rd_done) seen++; end
      reset_n = 1'b1;
      repeat (5) begin tick(); if (rd_valid || rd_done || rd_busy) seen++; end
      chk("t6b_quiet", 32'(seen), 32'd0);
      wadr_m = 0;
      run_to(50);
      do_trig(3, 4);
      expect_readout("t6b_after", 47, 4);

      // Read window straddling the ring wrap
      run_to(2);
      do_trig(5, 8);
      expect_readout("t2", 2045, 8);
      chk("t2_perr", 32'(parity_err), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
